atom_reg_bank: RTL and testbench
================================

ATOM_REG_BANK -- requirements
Module: atom_reg_bank

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data word width in bits (legal range 1..64).
REQ-002 Parameter CHANNELS, default 4, SHALL set the number of live registers (legal range 2..16).
REQ-003 Parameter ADDR_W, default 2, SHALL set the channel address width; the integrator sets it to ceil(log2(CHANNELS)).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 wr_valid  input  1  staging write request.
REQ-007 wr_ready  output  1  staging write accepted when wr_valid and wr_ready are both high.
REQ-008 wr_addr  input  ADDR_W  target channel of the staging write.
REQ-009 wr_data  input  WIDTH  staging write data.
REQ-010 lock_set  input  1  pulse; sets the lock bit of channel lock_addr.
REQ-011 lock_clr  input  1  pulse; clears the lock bit of channel lock_addr.
REQ-012 lock_addr  input  ADDR_W  channel addressed by lock_set/lock_clr.
REQ-013 commit  input  1  pulse; requests an atomic copy of staged words to the live registers.
REQ-014 data_out  output  CHANNELS*WIDTH  live registers; channel n occupies bits [n*WIDTH +: WIDTH].
REQ-015 lock_out  output  CHANNELS  current lock bits.
REQ-016 staged_out  output  CHANNELS  staged-valid mask.
REQ-017 err  output  1  one-cycle pulse on a rejected write.
REQ-018 par_out  output  CHANNELS  per-channel parity (see Configuration).

Function
REQ-019 The state machine SHALL have states IDLE (no staged bits), STAGED (at least one staged bit) and COMMIT (one-cycle copy).
REQ-020 wr_ready SHALL be high in IDLE and STAGED and low in COMMIT.
REQ-021 An accepted write to an unlocked channel SHALL load the staging word, set its staged bit, and move IDLE to STAGED on the same edge.
REQ-022 An accepted write to a locked channel SHALL leave staging unchanged and pulse err high for exactly the next cycle.
REQ-023 A write with wr_addr >= CHANNELS SHALL be rejected with an err pulse.
REQ-024 commit sampled high in IDLE or STAGED SHALL enter COMMIT on the next edge; commit is ignored in COMMIT.
REQ-025 On the edge leaving COMMIT, every channel that is staged and unlocked SHALL copy its staging word to data_out and clear its staged bit, all in the same edge; all other channels are unchanged.
REQ-026 Staged bits of locked channels SHALL survive a commit, and their words are committed by the first commit after unlock.
REQ-027 COMMIT SHALL exit to STAGED if any staged bit remains, otherwise to IDLE.
REQ-028 A write and commit in the same cycle SHALL stage the write first, and the following COMMIT includes it (write-to-live latency 2 cycles).
REQ-029 lock_set and lock_clr to the same channel in the same cycle SHALL resolve as lock_set.
REQ-030 Lock state sampled during the COMMIT cycle SHALL govern the copy, so a lock_set in the same cycle as commit blocks that channel (lock takes effect next edge, commit copies one edge later).
REQ-031 A rewrite of an already staged channel SHALL overwrite the staging word, with the last write winning.

Reset
REQ-032 rst high SHALL asynchronously force the state to IDLE, and data_out, staging, lock_out, staged_out, err and par_out to zero.
REQ-033 rst asserted mid-COMMIT SHALL abort the copy, so no partial update is visible after release.
REQ-034 The first edge after rst deasserts SHALL accept writes, so wr_ready is high during and after reset.

Configuration
REQ-035 When macro ATOM_REG_PARITY_EN is defined, par_out[n] SHALL be the XOR of data_out channel n, registered with data_out, so it updates on the same edge.
REQ-036 When ATOM_REG_PARITY_EN is undefined, par_out SHALL be constant zero and no parity logic is instantiated.

Verification
REQ-037 Reset, write ch1=0xA5, commit -> data_out ch1=0xA5 two edges after the write; staged_out=0; err never high.
REQ-038 lock_set ch2, write ch2=0x3C -> err one cycle, staged_out[2]=0, data_out ch2 stays 0x00.
REQ-039 Write ch0=0x11 and ch3=0x22, lock_set ch3, commit -> ch0=0x11, ch3=0x00, staged_out=4'b1000; lock_clr ch3, commit -> ch3=0x22, staged_out=0.
REQ-040 Write ch1 and commit in the same cycle, plus a write ch2 during COMMIT -> wr_ready low in COMMIT, the ch2 write is not accepted, only ch1 updates.
REQ-041 Assert rst during COMMIT after staging ch0=0xFF -> data_out all zero after release, state IDLE.
REQ-042 With ATOM_REG_PARITY_EN, commit ch0=0x07 -> par_out[0]=1; without it -> par_out=0.

Source files
------------

// File: rtl/atom_reg_bank.sv
// rtl/atom_reg_bank.sv - staged register bank with per-channel locks and atomic commit
// Optional per-channel parity on the live registers is enabled by defining ATOM_REG_PARITY_EN.
module atom_reg_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int ADDR_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      lock_set,
    input  logic                      lock_clr,
    input  logic [ADDR_W-1:0]         lock_addr,
    input  logic                      commit,
    output logic [CHANNELS*WIDTH-1:0] data_out,
    output logic [CHANNELS-1:0]       lock_out,
    output logic [CHANNELS-1:0]       staged_out,
    output logic                      err,
    output logic [CHANNELS-1:0]       par_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STAGED = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] CH_LIM = (ADDR_W+1)'(CHANNELS);

    state_t                      state_q, state_d;
    logic [WIDTH-1:0]            stage_q [CHANNELS];
    logic [WIDTH-1:0]            stage_d [CHANNELS];
    logic [CHANNELS-1:0]         staged_q, staged_d;
    logic [CHANNELS-1:0]         lock_q, lock_d;
    logic [CHANNELS*WIDTH-1:0]   data_q, data_d;
    logic                        err_q, err_d;
    logic                        wr_fire;
    logic                        addr_ok;
    logic                        wr_ok;

    assign wr_ready = (state_q != COMMIT);
    assign wr_fire  = wr_valid && wr_ready;
    assign addr_ok  = ({1'b0, wr_addr} < CH_LIM);
    // Out-of-range addresses never index the lock vector.
    assign wr_ok    = wr_fire && addr_ok && !lock_q[wr_addr];
    assign err_d    = wr_fire && !wr_ok;

    // Set wins over clear when both target the same channel.
    always_comb begin
        lock_d = lock_q;
        for (int n = 0; n < CHANNELS; n++) begin
            if (lock_set && lock_addr == ADDR_W'(n)) begin
                lock_d[n] = 1'b1;
            end else if (lock_clr && lock_addr == ADDR_W'(n)) begin
                lock_d[n] = 1'b0;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        staged_d = staged_q;
        data_d   = data_q;
        case (state_q)
            COMMIT: begin
                // Copy uses the lock bits held during this cycle, not lock_d.
                for (int n = 0; n < CHANNELS; n++) begin
                    if (staged_q[n] && !lock_q[n]) begin
                        data_d[n*WIDTH +: WIDTH] = stage_q[n];
                        staged_d[n]              = 1'b0;
                    end
                end
                state_d = (|staged_d) ? STAGED : IDLE;
            end
            default: begin
                if (wr_ok) begin
                    stage_d[wr_addr]  = wr_data;
                    staged_d[wr_addr] = 1'b1;
                end
                if (commit) begin
                    state_d = COMMIT;
                end else begin
                    state_d = (|staged_d) ? STAGED : IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            stage_q  <= '{default: '0};
            staged_q <= '0;
            lock_q   <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            staged_q <= staged_d;
            lock_q   <= lock_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

`ifdef ATOM_REG_PARITY_EN
    logic [CHANNELS-1:0] par_q, par_d;

    always_comb begin
        par_d = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            par_d[n] = ^data_d[n*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= '0;
        end else begin
            par_q <= par_d;
        end
    end

    assign par_out = par_q;
`else
    assign par_out = '0;
`endif

    assign data_out   = data_q;
    assign lock_out   = lock_q;
    assign staged_out = staged_q;
    assign err        = err_q;

endmodule

// File: tb/tb_atom_reg_bank.sv
// tb/tb_atom_reg_bank.sv - directed vector bench for atom_reg_bank
module tb_atom_reg_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [1:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        lock_set;
    logic        lock_clr;
    logic [1:0]  lock_addr;
    logic        commit;
    logic [31:0] data_out;
    logic [3:0]  lock_out;
    logic [3:0]  staged_out;
    logic        err;
    logic [3:0]  par_out;

    int checks = 0;
    int errors = 0;

    atom_reg_bank #(.WIDTH(8), .CHANNELS(4), .ADDR_W(2)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .lock_set(lock_set), .lock_clr(lock_clr), .lock_addr(lock_addr),
        .commit(commit),
        .data_out(data_out), .lock_out(lock_out), .staged_out(staged_out),
        .err(err), .par_out(par_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wv;
        logic [1:0]  wa;
        logic [7:0]  wd;
        logic        ls;
        logic        lc;
        logic [1:0]  la;
        logic        cm;
        logic [31:0] ed;
        logic [3:0]  el;
        logic [3:0]  es;
        logic        ee;
        logic        er;
    } vec_t;

    vec_t vt[27];

    function automatic vec_t mk(input logic wv, input logic [1:0] wa, input logic [7:0] wd,
                                input logic ls, input logic lc, input logic [1:0] la,
                                input logic cm, input logic [31:0] ed, input logic [3:0] el,
                                input logic [3:0] es, input logic ee, input logic er);
        vec_t v;
        v.wv = wv; v.wa = wa; v.wd = wd; v.ls = ls; v.lc = lc; v.la = la; v.cm = cm;
        v.ed = ed; v.el = el; v.es = es; v.ee = ee; v.er = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wr_valid = 0; wr_addr = 0; wr_data = 0;
        lock_set = 0; lock_clr = 0; lock_addr = 0; commit = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_par;

        // wv wa wd     ls lc la cm   data          lock    staged  err rdy
        vt[0]  = mk(1, 1, 8'hA5, 0, 0, 0, 1, 32'h00000000, 4'b0000, 4'b0010, 0, 0);
        vt[1]  = mk(0, 0, 8'h00, 0, 0, 0, 0, 32'h0000A500, 4'b0000, 4'b0000, 0, 1);
        vt[2]  = mk(0, 0, 8'h00, 1, 0, 2, 0, 32'h0000A500, 4'b0100, 4'b0000, 0, 1);
        vt[3]  = mk(1, 2, 8'h3C, 0, 0, 0, 0, 32'h0000A500, 4'b0100, 4'b0000, 1, 1);
        vt[4]  = mk(0, 0, 8'h00, 0, 0, 0, 0, 32'h0000A500, 4'b0100, 4'b0000, 0, 1);
        vt[5]  = mk(0, 0, 8'h00, 0, 1, 2, 0, 32'h0000A500, 4'b0000, 4'b0000, 0, 1);
        vt[6]  = mk(1, 0, 8'h11, 0, 0, 0, 0, 32'h0000A500, 4'b0000, 4'b0001, 0, 1);
        vt[7]  = mk(1, 3, 8'h22, 1, 0, 3, 0, 32'h0000A500, 4'b1000, 4'b1001, 0, 1);
        vt[8]  = mk(0, 0, 8'h00, 0, 0, 0, 1, 32'h0000A500, 4'b1000, 4'b1001, 0, 0);
        vt[9]  = mk(0, 0, 8'h00, 0, 0, 0, 0, 32'h0000A511, 4'b1000, 4'b1000, 0, 1);
        vt[10] = mk(0, 0, 8'h00, 0, 1, 3, 1, 32'h0000A511, 4'b0000, 4'b1000, 0, 0);
        vt[11] = mk(0, 0, 8'h00, 0, 0, 0, 0, 32'h2200A511, 4'b0000, 4'b0000, 0, 1);
        vt[12] = mk(1, 1, 8'h5A, 0, 0, 0, 1, 32'h2200A511, 4'b0000, 4'b0010, 0, 0);
        vt[13] = mk(1, 2, 8'h77, 0, 0, 0, 0, 32'h22005A11, 4'b0000, 4'b0000, 0, 1);
        vt[14] = mk(0, 0, 8'h00, 0, 0, 0, 0, 32'h22005A11, 4'b0000, 4'b0000, 0, 1);
        vt[15] = mk(0, 0, 8'h00, 1, 1, 1, 0, 32'h22005A11, 4'b0010, 4'b0000, 0, 1);
        vt[16] = mk(0, 0, 8'h00, 0, 1, 1, 0, 32'h22005A11, 4'b0000, 4'b0000, 0, 1);
        vt[17] = mk(1, 0, 8'h01, 0, 0, 0, 0, 32'h22005A11, 4'b0000, 4'b0001, 0, 1);
        vt[18] = mk(1, 0, 8'h02, 0, 0, 0, 0, 32'h22005A11, 4'b0000, 4'b0001, 0, 1);
        vt[19] = mk(0, 0, 8'h00, 0, 0, 0, 1, 32'h22005A11, 4'b0000, 4'b0001, 0, 0);
        vt[20] = mk(0, 0, 8'h00, 0, 0, 0, 0, 32'h22005A02, 4'b0000, 4'b0000, 0, 1);
        vt[21] = mk(1, 1, 8'h33, 0, 0, 0, 0, 32'h22005A02, 4'b0000, 4'b0010, 0, 1);
        vt[22] = mk(0, 0, 8'h00, 1, 0, 1, 1, 32'h22005A02, 4'b0010, 4'b0010, 0, 0);
        vt[23] = mk(0, 0, 8'h00, 0, 0, 0, 0, 32'h22005A02, 4'b0010, 4'b0010, 0, 1);
        vt[24] = mk(0, 0, 8'h00, 0, 1, 1, 0, 32'h22005A02, 4'b0000, 4'b0010, 0, 1);
        vt[25] = mk(0, 0, 8'h00, 0, 0, 0, 1, 32'h22005A02, 4'b0000, 4'b0010, 0, 0);
        vt[26] = mk(0, 0, 8'h00, 0, 0, 0, 0, 32'h22003302, 4'b0000, 4'b0000, 0, 1);

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset data_out", data_out, 32'h0);
        chk("reset lock_out", {28'h0, lock_out}, 32'h0);
        chk("reset staged_out", {28'h0, staged_out}, 32'h0);
        chk("reset err", {31'h0, err}, 32'h0);
        chk("reset par_out", {28'h0, par_out}, 32'h0);
        chk("reset wr_ready", {31'h0, wr_ready}, 32'h1);
        rst = 1'b0;

        for (int i = 0; i < 27; i++) begin
            wr_valid = vt[i].wv; wr_addr = vt[i].wa; wr_data = vt[i].wd;
            lock_set = vt[i].ls; lock_clr = vt[i].lc; lock_addr = vt[i].la;
            commit = vt[i].cm;
            step();
            chk($sformatf("vec%0d data_out", i), data_out, vt[i].ed);
            chk($sformatf("vec%0d lock_out", i), {28'h0, lock_out}, {28'h0, vt[i].el});
            chk($sformatf("vec%0d staged_out", i), {28'h0, staged_out}, {28'h0, vt[i].es});
            chk($sformatf("vec%0d err", i), {31'h0, err}, {31'h0, vt[i].ee});
            chk($sformatf("vec%0d wr_ready", i), {31'h0, wr_ready}, {31'h0, vt[i].er});
        end
        idle_inputs();

        // Reset during COMMIT aborts the pending copy of ch0=0xFF.
        rst = 1'b1;
        step();
        rst = 1'b0;
        wr_valid = 1; wr_addr = 0; wr_data = 8'hFF; commit = 1;
        step();
        idle_inputs();
        chk("abort in COMMIT wr_ready", {31'h0, wr_ready}, 32'h0);
        rst = 1'b1;
        #1;
        chk("abort async data_out", data_out, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("abort data_out", data_out, 32'h0);
        chk("abort staged_out", {28'h0, staged_out}, 32'h0);
        chk("abort wr_ready", {31'h0, wr_ready}, 32'h1);
        step();
        chk("abort later data_out", data_out, 32'h0);

        // Parity follows the committed word on the same edge.
        wr_valid = 1; wr_addr = 0; wr_data = 8'h07; commit = 1;
        step();
        idle_inputs();
        step();
`ifdef ATOM_REG_PARITY_EN
        exp_par = 4'b0001;
`else
        exp_par = 4'b0000;
`endif
        chk("parity data_out", data_out, 32'h00000007);
        chk("parity par_out", {28'h0, par_out}, {28'h0, exp_par});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
